// File: rtl/vector_packer.sv
// Collects a serial stream of W-bit elements into one N-lane flat vector and
// hands it to the reduction tree as a single-cycle valid/ready transfer.
module vector_packer #(
  parameter int N  = 1024,
  parameter int W  = 16,
  parameter int CW = $clog2(N+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N*W-1:0]  m_flat,
  output logic [CW-1:0]   m_count
);

  localparam int IW = $clog2(N);

  typedef enum logic {FILL, SEND} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic          accept;
  logic          close;

  logic [W-1:0]  lane_q [N];
  logic [W-1:0]  lane_d [N];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    accept  = 1'b0;
    close   = 1'b0;
    case (state_q)
      FILL: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid) begin
          close = s_last || (idx_q == IW'(N-1));
          if (close) begin
            state_d = SEND;
            count_d = CW'(idx_q) + CW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      SEND: begin
        m_valid = 1'b1;
        // m_valid drops right after the transfer: the next vector needs at least one new element
        if (m_ready) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Lanes above the closing index are cleared on close so a short vector sums correctly.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    always_comb begin
      lane_d[gi] = lane_q[gi];
      if (accept && (idx_q == IW'(gi))) begin
        lane_d[gi] = s_data;
      end else if (close && (idx_q < IW'(gi))) begin
        lane_d[gi] = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_q[gi] <= '0;
      end else begin
        lane_q[gi] <= lane_d[gi];
      end
    end

    assign m_flat[gi*W +: W] = lane_q[gi];
  end

  assign m_count = count_q;

endmodule
